// File: rtl/display_mux4.sv
// Four-digit multiplexed 7-segment driver for the clock display.
// Scans minutes/hours BCD digits with blink, decimal point and leading-zero blanking.
module display_mux4 #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_TICKS = 250,
    parameter bit AN_ACT_LOW  = 1'b1,
    parameter bit SEG_ACT_LOW = 1'b1
) (
    input  logic       ck,
    input  logic       rst,
    input  logic [3:0] display1,
    input  logic [3:0] display2,
    input  logic [3:0] display3,
    input  logic [3:0] display4,
    input  logic [3:0] blink_mask,
    input  logic [3:0] dp_mask,
    input  logic       blank_lz,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] B_LAST = BW'(BLINK_TICKS - 1);

    logic [PW-1:0] pcnt;
    logic [BW-1:0] bcnt;
    logic [1:0]    sel;
    logic          bphase;
    logic          tick;

    logic [3:0] digit;
    logic       blank;
    logic [3:0] an_l;
    logic [6:0] seg_l;
    logic       dp_l;

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    assign tick = (pcnt == P_LAST);

    always_comb begin
        digit = display1;
        unique case (sel)
            2'd0: digit = display1;
            2'd1: digit = display2;
            2'd2: digit = display3;
            2'd3: digit = display4;
        endcase
        // Blanked digits keep their anode on so every slot has equal on-time.
        blank = (bphase & blink_mask[sel])
              | ((sel == 2'd3) & blank_lz & (display4 == 4'd0));
        seg_l = blank ? 7'h00 : decode(digit);
        an_l  = 4'b0001 << sel;
        dp_l  = dp_mask[sel];
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            pcnt   <= '0;
            sel    <= 2'd0;
            bcnt   <= '0;
            bphase <= 1'b0;
            an     <= {4{AN_ACT_LOW}};
            seg    <= {7{SEG_ACT_LOW}};
            dp     <= SEG_ACT_LOW;
        end else begin
            pcnt <= tick ? '0 : pcnt + 1'b1;
            if (tick) begin
                sel <= sel + 2'd1;
                if (bcnt == B_LAST) begin
                    bcnt   <= '0;
                    bphase <= ~bphase;
                end else begin
                    bcnt <= bcnt + 1'b1;
                end
            end
            an  <= an_l ^ {4{AN_ACT_LOW}};
            seg <= seg_l ^ {7{SEG_ACT_LOW}};
            dp  <= dp_l ^ SEG_ACT_LOW;
        end
    end

endmodule

// File: tb/tb_display_mux4.sv
// Scoreboard bench for display_mux4: stimulus queues expected frames,
// a negedge monitor pops and compares them cycle by cycle.
module tb_display_mux4;

    localparam int RD = 4;
    localparam int BT = 2;

    logic       ck = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] display1 = 4'd0;
    logic [3:0] display2 = 4'd0;
    logic [3:0] display3 = 4'd0;
    logic [3:0] display4 = 4'd0;
    logic [3:0] blink_mask = 4'd0;
    logic [3:0] dp_mask = 4'd0;
    logic       blank_lz = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    typedef struct {
        int         cyc;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        string      tag;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   done = 1'b0;

    display_mux4 #(
        .REFRESH_DIV(RD),
        .BLINK_TICKS(BT),
        .AN_ACT_LOW (1'b1),
        .SEG_ACT_LOW(1'b1)
    ) dut (
        .ck        (ck),
        .rst       (rst),
        .display1  (display1),
        .display2  (display2),
        .display3  (display3),
        .display4  (display4),
        .blink_mask(blink_mask),
        .dp_mask   (dp_mask),
        .blank_lz  (blank_lz),
        .an        (an),
        .seg       (seg),
        .dp        (dp)
    );

    always #5 ck = ~ck;

    always @(posedge ck) cyc++;

    function automatic logic [6:0] seg_on(input logic [3:0] v);
        logic [6:0] t [16];
        t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
        return t[v];
    endfunction

    task automatic push(input int c, input logic [3:0] a, input logic [6:0] s,
                        input logic d, input string tag);
        exp_t e;
        e.cyc = c;
        e.an  = a;
        e.seg = s;
        e.dp  = d;
        e.tag = tag;
        q.push_back(e);
    endtask

    task automatic scan(input logic [3:0] d1, input logic [3:0] d2,
                        input logic [3:0] d3, input logic [3:0] d4,
                        input logic [3:0] bm, input logic [3:0] dm,
                        input logic bl, input int n, input string tag);
        int         base;
        int         d;
        bit         ph;
        bit         blk;
        logic [3:0] v;
        logic [3:0] one;
        @(negedge ck);
        display1 = d1;
        display2 = d2;
        display3 = d3;
        display4 = d4;
        blink_mask = bm;
        dp_mask = dm;
        blank_lz = bl;
        rst = 1'b1;
        for (int k = 1; k <= 3; k++) push(cyc + k, 4'hF, 7'h7F, 1'b1, {tag, "_rst"});
        repeat (3) @(negedge ck);
        rst = 1'b0;
        base = cyc + 1;
        for (int i = 0; i < n; i++) begin
            d  = (i / RD) % 4;
            ph = ((i / (RD * BT)) % 2) == 1;
            case (d)
                0: v = d1;
                1: v = d2;
                2: v = d3;
                default: v = d4;
            endcase
            blk = (ph && bm[d]) || (d == 3 && bl && d4 == 4'd0);
            one = 4'b0001 << d;
            push(base + i, ~one, blk ? 7'h7F : ~seg_on(v), ~dm[d], tag);
        end
        repeat (n) @(negedge ck);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge ck);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                n_cmp++;
                if (e.cyc < cyc) begin
                    n_bad++;
                    $display("FAIL %s: missed check at cycle %0d (now %0d)", e.tag, e.cyc, cyc);
                end else if (an !== e.an || seg !== e.seg || dp !== e.dp) begin
                    n_bad++;
                    $display("FAIL %s cyc=%0d: got an=%h seg=%h dp=%b, want an=%h seg=%h dp=%b",
                             e.tag, cyc, an, seg, dp, e.an, e.seg, e.dp);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        if (!done) begin
            $display("FAIL watchdog: bench did not complete, %0d checks pending", q.size());
            $fatal(1, "timeout");
        end
    end

    initial begin : stim
        repeat (2) @(negedge ck);
        scan(4'd0, 4'd0, 4'd0, 4'd0, 4'b0000, 4'b0000, 1'b0, 4, "reset");
        scan(4'd9, 4'd5, 4'd3, 4'd2, 4'b0000, 4'b0000, 1'b0, 20, "scan");
        scan(4'd4, 4'd3, 4'd2, 4'd1, 4'b0011, 4'b0000, 1'b0, 16, "blink_lo");
        scan(4'd4, 4'd3, 4'd2, 4'd1, 4'b1100, 4'b0000, 1'b0, 16, "blink_hi");
        scan(4'd4, 4'd3, 4'd2, 4'd1, 4'b1111, 4'b0000, 1'b0, 32, "blink_all");
        scan(4'd6, 4'd1, 4'd7, 4'd0, 4'b0000, 4'b0000, 1'b1, 16, "lz_on");
        scan(4'd6, 4'd1, 4'd7, 4'd0, 4'b0000, 4'b0000, 1'b0, 16, "lz_off");
        scan(4'd8, 4'd9, 4'd0, 4'd0, 4'b0000, 4'b0000, 1'b1, 16, "lz_zero");
        scan(4'd6, 4'hC, 4'd8, 4'd1, 4'b0000, 4'b0100, 1'b0, 16, "dp_inv");
        scan(4'hF, 4'hA, 4'hE, 4'd5, 4'b0000, 4'b1011, 1'b1, 16, "dash");
        scan(4'd9, 4'd5, 4'd3, 4'd2, 4'b0000, 4'b0000, 1'b0, 9, "pre_mid");
        scan(4'd9, 4'd5, 4'd3, 4'd2, 4'b0000, 4'b0000, 1'b0, 8, "mid_rst");
        repeat (3) @(negedge ck);
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected frames never compared, want 0", q.size());
        end
        done = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
